// File: rtl/rs232_tx.sv
// rs232_tx: 8N1 UART transmitter fed from a synchronous FIFO read port.
// Pops one byte per frame. The FIFO read data is captured in the FETCH cycle.
// The byte is then shifted out LSB first on the registered tx pin.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, pop a byte as soon as the FIFO is not empty
// FETCH | one cycle, FIFO read data captured into the buffer
// START | start bit (line low) for CLKS_PER_BIT cycles
// BIT0-7| data bit n of the buffer for CLKS_PER_BIT cycles
// STOP  | stop bit (line high) for CLKS_PER_BIT cycles
module rs232_tx #(
   parameter int CLKS_PER_BIT = 9
) (
   input  logic       clk_tx,
   input  logic       rst_n,
   input  logic       empty,
   input  logic [7:0] din,
   output logic       rd_clk,
   output logic       rd_en,
   output logic       tx,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      IDLE, FETCH, START,
      BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7,
      STOP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       shreg;
   logic             tx_nxt;
   logic             rd_req;

   assign rd_clk = clk_tx;
   assign busy   = (state != IDLE);
   // The state register sits at IDLE during reset, so gate the pop strobe explicitly.
   assign rd_en  = rd_req & rst_n;

   // Next-state, bit-period counter and pop request.
   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      cnt_nxt   = '0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               rd_req    = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: state_nxt = START;
         START: begin
            if (cnt == CNT_LAST) state_nxt = BIT0;
         end
         BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6: begin
            if (cnt == CNT_LAST) state_nxt = state_t'(state + 4'd1);
         end
         BIT7: begin
            if (cnt == CNT_LAST) state_nxt = STOP;
         end
         STOP: begin
            if (cnt == CNT_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt == state && state != IDLE && state != FETCH) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // Line level for the state about to be entered; registering it keeps tx glitch-free.
   always_comb begin
      tx_nxt = 1'b1;
      unique case (state_nxt)
         START:   tx_nxt = 1'b0;
         BIT0:    tx_nxt = shreg[0];
         BIT1:    tx_nxt = shreg[1];
         BIT2:    tx_nxt = shreg[2];
         BIT3:    tx_nxt = shreg[3];
         BIT4:    tx_nxt = shreg[4];
         BIT5:    tx_nxt = shreg[5];
         BIT6:    tx_nxt = shreg[6];
         BIT7:    tx_nxt = shreg[7];
         default: tx_nxt = 1'b1;
      endcase
   end

   // State, counter and line register.
   always_ff @(posedge clk_tx or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tx    <= tx_nxt;
      end
   end

   // Buffer loads only in FETCH, so the byte in flight is immune to FIFO activity.
   always_ff @(posedge clk_tx or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (state == FETCH) begin
         shreg <= din;
      end
   end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: three instances (C = 9, 2, 16) each fed by a small FIFO model.
// A per-instance monitor decodes frames from tx and checks them against a queue of
// expected bytes. The main process issues directed stimulus and checks timing logs.
module tb_rs232_tx;

   logic clk_tx = 1'b0;
   logic rst_n  = 1'b1;
   always #5 clk_tx = ~clk_tx;

   logic       empty_s [3];
   logic [7:0] din_s   [3];
   wire        rd_clk_w[3];
   wire        rd_en_w [3];
   wire        tx_w    [3];
   wire        busy_w  [3];

   logic [7:0] fifo_q [3][$];
   logic [7:0] exp_q  [3][$];
   int         rd_iv  [3][$];
   int         gaps   [3][$];
   int         busy_runs[3][$];
   int         pulses [3];
   int         last_rd[3];
   int         lowcnt [3];
   logic       scramble[3];

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic clr(input int i);
      pulses[i] = 0;
      last_rd[i] = -1;
      lowcnt[i] = 0;
      rd_iv[i].delete();
      gaps[i].delete();
      busy_runs[i].delete();
   endtask

   task automatic push(input int i, input logic [7:0] b);
      fifo_q[i].push_back(b);
      exp_q[i].push_back(b);
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int C = (gi == 0) ? 9 : ((gi == 1) ? 2 : 16);

      rs232_tx #(.CLKS_PER_BIT(C)) dut (
         .clk_tx (clk_tx),
         .rst_n  (rst_n),
         .empty  (empty_s[gi]),
         .din    (din_s[gi]),
         .rd_clk (rd_clk_w[gi]),
         .rd_en  (rd_en_w[gi]),
         .tx     (tx_w[gi]),
         .busy   (busy_w[gi])
      );

      // FIFO model: pop seen during a cycle -> data presented just after that edge.
      logic pop;
      initial begin
         empty_s[gi] = 1'b1;
         din_s[gi]   = 8'h00;
         scramble[gi] = 1'b0;
         forever begin
            @(negedge clk_tx);
            pop = rd_en_w[gi];
            @(posedge clk_tx);
            #1;
            if (pop && fifo_q[gi].size() > 0) din_s[gi] = fifo_q[gi].pop_front();
            else if (scramble[gi]) din_s[gi] = 8'($urandom);
            empty_s[gi] = (fifo_q[gi].size() == 0);
         end
      end

      // Monitor: logs rd_en/busy timing and decodes frames from tx.
      int active = 0, pos = 0, werr = 0, high_run = 0, have_prev = 0, brun = 0, cyc = 0;
      int lvl[10];
      logic [7:0] dec;
      initial begin
         forever begin
            @(negedge clk_tx);
            cyc++;
            if (!rst_n) begin
               active = 0; high_run = 0; have_prev = 0; brun = 0;
               continue;
            end
            if (rd_en_w[gi]) begin
               pulses[gi]++;
               if (last_rd[gi] >= 0) rd_iv[gi].push_back(cyc - last_rd[gi]);
               last_rd[gi] = cyc;
            end
            if (busy_w[gi]) brun++;
            else if (brun > 0) begin
               busy_runs[gi].push_back(brun);
               brun = 0;
            end
            if (tx_w[gi] == 1'b0) lowcnt[gi]++;
            if (active == 0) begin
               if (tx_w[gi] == 1'b0) begin
                  active = 1; pos = 0; werr = 0;
                  if (have_prev != 0) gaps[gi].push_back(high_run + C);
                  high_run = 0;
               end else begin
                  high_run++;
               end
            end
            if (active != 0) begin
               if (pos % C == 0) lvl[pos / C] = int'(tx_w[gi]);
               else if (int'(tx_w[gi]) != lvl[pos / C]) werr++;
               pos++;
               if (pos == 10 * C) begin
                  active = 0;
                  have_prev = 1;
                  for (int k = 0; k < 8; k++) dec[k] = lvl[k + 1][0];
                  chk($sformatf("start bit c%0d", C), lvl[0], 0);
                  chk($sformatf("stop bit c%0d", C), lvl[9], 1);
                  chk($sformatf("bit width c%0d", C), werr, 0);
                  if (exp_q[gi].size() == 0) chk($sformatf("unexpected frame c%0d", C), int'(dec), -1);
                  else chk($sformatf("byte c%0d", C), int'(dec), int'(exp_q[gi].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) clr(i);

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("reset tx", int'(tx_w[0]), 1);
      chk("reset busy", int'(busy_w[0]), 0);
      chk("reset rd_en", int'(rd_en_w[0]), 0);
      repeat (3) @(negedge clk_tx);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_tx);

      // Single byte A5
      clr(0);
      push(0, 8'hA5);
      repeat (120) @(negedge clk_tx);
      chk("single rd_en pulses", pulses[0], 1);
      chk("single drained", exp_q[0].size(), 0);
      chk("single busy runs", busy_runs[0].size(), 1);
      if (busy_runs[0].size() > 0) chk("single busy length", busy_runs[0][0], 91);

      // Back-to-back 00, FF, 55
      clr(0);
      push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
      repeat (3 * 92 + 20) @(negedge clk_tx);
      chk("b2b rd_en pulses", pulses[0], 3);
      chk("b2b drained", exp_q[0].size(), 0);
      chk("b2b intervals", rd_iv[0].size(), 2);
      for (int k = 0; k < rd_iv[0].size(); k++) chk("b2b rd_en spacing", rd_iv[0][k], 92);
      chk("b2b gap count", gaps[0].size(), 3);
      for (int k = 1; k < gaps[0].size(); k++) chk("b2b high cycles", gaps[0][k], 11);

      // Empty gating, then zero-latency pop when empty drops
      clr(0);
      repeat (500) @(negedge clk_tx);
      chk("gated rd_en pulses", pulses[0], 0);
      chk("gated tx low cycles", lowcnt[0], 0);
      push(0, 8'hC3);
      @(posedge clk_tx);
      #2;
      chk("empty drop empty", int'(empty_s[0]), 0);
      chk("empty drop rd_en", int'(rd_en_w[0]), 1);
      repeat (100) @(negedge clk_tx);
      chk("empty drop drained", exp_q[0].size(), 0);

      // Data stability: din scrambled every cycle while a frame is in flight
      scramble[0] = 1'b1;
      push(0, 8'h3C);
      repeat (100) @(negedge clk_tx);
      scramble[0] = 1'b0;
      chk("stability drained", exp_q[0].size(), 0);

      // Reset mid-frame with another byte waiting
      push(0, 8'h96); push(0, 8'h11);
      repeat (40) @(negedge clk_tx);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset empty", int'(empty_s[0]), 0);
      chk("midreset tx", int'(tx_w[0]), 1);
      chk("midreset busy", int'(busy_w[0]), 0);
      chk("midreset rd_en", int'(rd_en_w[0]), 0);
      fifo_q[0].delete();
      exp_q[0].delete();
      repeat (3) @(negedge clk_tx);
      rst_n = 1'b1;
      clr(0);
      repeat (50) @(negedge clk_tx);
      chk("post reset rd_en pulses", pulses[0], 0);
      chk("post reset tx low cycles", lowcnt[0], 0);
      chk("post reset busy", int'(busy_w[0]), 0);

      // Parameter sweep C=2 and C=16, two frames of 81 each
      clr(1); clr(2);
      push(1, 8'h81); push(1, 8'h81);
      push(2, 8'h81); push(2, 8'h81);
      repeat (400) @(negedge clk_tx);
      chk("c2 rd_en pulses", pulses[1], 2);
      chk("c16 rd_en pulses", pulses[2], 2);
      chk("c2 drained", exp_q[1].size(), 0);
      chk("c16 drained", exp_q[2].size(), 0);
      chk("c2 intervals", rd_iv[1].size(), 1);
      chk("c16 intervals", rd_iv[2].size(), 1);
      if (rd_iv[1].size() > 0) chk("c2 frame period", rd_iv[1][0], 22);
      if (rd_iv[2].size() > 0) chk("c16 frame period", rd_iv[2][0], 162);
      if (busy_runs[1].size() > 0) chk("c2 busy length", busy_runs[1][0], 21);
      if (busy_runs[2].size() > 0) chk("c16 busy length", busy_runs[2][0], 161);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
